// File: rtl/sargam_pkg.sv
// Shared sargam note encoding, full-period table and match-window helper.
// Periods are in 50 MHz clk cycles and equal twice the generator's half-period plus two.
package sargam_pkg;

    localparam int NUM_NOTES = 7;

    typedef enum logic [2:0] {
        NOTE_SA  = 3'd0,
        NOTE_RE  = 3'd1,
        NOTE_GA  = 3'd2,
        NOTE_MA  = 3'd3,
        NOTE_PA  = 3'd4,
        NOTE_DHA = 3'd5,
        NOTE_NI  = 3'd6
    } note_t;

    localparam logic [0:NUM_NOTES-1][31:0] NOTE_PERIOD = '{
        32'd191114, 32'd170264, 32'd151688, 32'd143268,
        32'd127326, 32'd113638, 32'd101044
    };

    typedef enum logic [1:0] {
        ST_SILENT,
        ST_ACQUIRE,
        ST_LOCKED
    } det_state_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } note_win_t;

    function automatic note_win_t note_window(input logic [31:0] period, input int tol_shift);
        note_win_t w;
        w.lo = period - (period >> tol_shift);
        w.hi = period + (period >> tol_shift);
        return w;
    endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises tone_in, detects rising edges and measures rising-to-rising distance.
// period/period_vld/edge_seen appear one cycle after the edge pulse; no backpressure.
// timeout is high while the counter sits saturated at TIMEOUT.
module tone_period_meter #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             edge_seen,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             edge_p;

    assign edge_p  = sync_q[1] & ~sync_q[2];
    assign timeout = (cnt_q == TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            edge_seen  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], tone_in};
            edge_seen  <= edge_p;
            // A saturated count means the true period is unknown: discard it.
            period_vld <= edge_p & ~timeout;
            if (edge_p) begin
                cnt_q <= '0;
                if (!timeout) begin
                    period <= cnt_q + 1'b1;
                end
            end else if (!timeout) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sargam_tone_detector.sv
// Classifies a measured tone period as Sa..Ni and tracks lock with a debounce FSM.
// Outputs change 2 cycles after the internal edge pulse; no backpressure.
// TONE_DET_PERIOD_OUT_EN adds period_out/period_stb for raw period observation.
module sargam_tone_detector
    import sargam_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int CNT_W      = 20,
    parameter int TOL_SHIFT  = 6,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int TIMEOUT    = CLK_HZ / 200,
    parameter logic [0:NUM_NOTES-1][31:0] PERIOD_TBL = NOTE_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    output logic       note_valid,
    output logic [2:0] note_idx,
    output logic [6:0] led,
    output logic       note_stb,
    output logic       silent
`ifdef TONE_DET_PERIOD_OUT_EN
    ,
    output logic [CNT_W-1:0] period_out,
    output logic             period_stb
`endif
);

    localparam int ACW = $clog2(LOCK_CNT + 1);
    localparam int MCW = $clog2(UNLOCK_CNT + 1);

    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             edge_seen;
    logic             timeout;

    tone_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_meter (
        .clk        (clk),
        .rst        (rst),
        .tone_in    (tone_in),
        .period     (period),
        .period_vld (period_vld),
        .edge_seen  (edge_seen),
        .timeout    (timeout)
    );

`ifdef TONE_DET_PERIOD_OUT_EN
    assign period_out = period;
    assign period_stb = period_vld;
`endif

    logic [31:0] per32;
    note_win_t   win;
    logic        match;
    note_t       match_idx;

    assign per32 = 32'(period);

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        win       = '0;
        match     = 1'b0;
        match_idx = NOTE_SA;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            win = note_window(PERIOD_TBL[i], TOL_SHIFT);
            if (per32 >= win.lo && per32 <= win.hi) begin
                match     = 1'b1;
                match_idx = note_t'(i[2:0]);
            end
        end
    end

    det_state_t     state_q, state_d;
    note_t          cand_q, cand_d;
    note_t          idx_q, idx_d;
    logic [ACW-1:0] count_q, count_d;
    logic [MCW-1:0] miss_q, miss_d;
    logic           stb_q, stb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SILENT;
            cand_q  <= NOTE_SA;
            idx_q   <= NOTE_SA;
            count_q <= '0;
            miss_q  <= '0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            miss_q  <= miss_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        idx_d   = idx_q;
        count_d = count_q;
        miss_d  = miss_q;
        stb_d   = 1'b0;
        if (timeout) begin
            state_d = ST_SILENT;
            count_d = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                ST_SILENT: begin
                    if (edge_seen) begin
                        state_d = ST_ACQUIRE;
                        count_d = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (period_vld) begin
                        if (!match) begin
                            count_d = '0;
                        end else if (match_idx == cand_q) begin
                            count_d = count_q + 1'b1;
                        end else begin
                            cand_d  = match_idx;
                            count_d = ACW'(1);
                        end
                        if (count_d == ACW'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                            idx_d   = cand_d;
                            miss_d  = '0;
                            stb_d   = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (period_vld) begin
                        if (match && match_idx == idx_q) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                            if (miss_d == MCW'(UNLOCK_CNT)) begin
                                state_d = ST_ACQUIRE;
                                miss_d  = '0;
                                cand_d  = match ? match_idx : cand_q;
                                count_d = match ? ACW'(1) : '0;
                            end
                        end
                    end
                end
                default: state_d = ST_SILENT;
            endcase
        end
    end

    assign note_valid = (state_q == ST_LOCKED);
    assign note_idx   = idx_q;
    assign led        = note_valid ? (7'b1 << idx_q) : 7'd0;
    assign note_stb   = stb_q;
    assign silent     = (state_q == ST_SILENT);

endmodule

// File: tb/tb_sargam_tone_detector.sv
// Directed bench for sargam_tone_detector with note periods scaled down ~1000x
// and a 600-cycle timeout so every scenario stays short.
module tb_sargam_tone_detector;

    localparam int SA  = 191;
    localparam int NI  = 101;
    localparam int PA  = 127;
    localparam int GA  = 152;
    localparam int MA  = 143;
    localparam int TMO = 600;
    localparam logic [0:6][31:0] TBL = '{
        32'd191, 32'd170, 32'd152, 32'd143, 32'd127, 32'd114, 32'd101
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tone_in = 1'b0;
    logic       note_valid;
    logic [2:0] note_idx;
    logic [6:0] led;
    logic       note_stb;
    logic       silent;
`ifdef TONE_DET_PERIOD_OUT_EN
    logic [19:0] period_out;
    logic        period_stb;
`endif

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int valid_cyc = 0;
    int low_cyc = 0;
    int s0, v0, l0;

    int ga_p[5]    = '{150, 154, 149, 155, 160};
    bit ga_lock[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    sargam_tone_detector #(
        .CNT_W      (20),
        .TOL_SHIFT  (6),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (2),
        .TIMEOUT    (TMO),
        .PERIOD_TBL (TBL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tone_in    (tone_in),
        .note_valid (note_valid),
        .note_idx   (note_idx),
        .led        (led),
        .note_stb   (note_stb),
        .silent     (silent)
`ifdef TONE_DET_PERIOD_OUT_EN
        ,
        .period_out (period_out),
        .period_stb (period_stb)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_stb === 1'b1) stb_cnt <= stb_cnt + 1;
        if (note_valid === 1'b1) valid_cyc <= valid_cyc + 1;
        else low_cyc <= low_cyc + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic period_n(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            tone_in = 1'b1;
            tick(p / 2);
            tone_in = 1'b0;
            tick(p - p / 2);
        end
    endtask

    // Raise tone and stop 3 cycles in, one cycle before the edge's effect shows.
    task automatic rise_probe();
        tone_in = 1'b1;
        tick(3);
    endtask

    task automatic finish_period(input int p, input int spent);
        tick(p / 2 - spent);
        tone_in = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tone_in = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_valid", note_valid, 1'b0);
        check("rst_idx", note_idx, 3'd0);
        check("rst_led", led, 7'd0);
        check("rst_stb", note_stb, 1'b0);
        check("rst_silent", silent, 1'b1);
        rst = 1'b0;

        // Sa lock: first edge discarded, four matches, lock 2 cycles after the 5th edge
        s0 = stb_cnt;
        period_n(SA, 4);
        check("sa_acq_valid", note_valid, 1'b0);
        check("sa_acq_silent", silent, 1'b0);
        rise_probe();
        check("sa_early", note_valid, 1'b0);
        tick(1);
        check("sa_valid", note_valid, 1'b1);
        check("sa_idx", note_idx, 3'd0);
        check("sa_led", led, 7'b0000001);
        check("sa_stb_on", note_stb, 1'b1);
        tick(1);
        check("sa_stb_off", note_stb, 1'b0);
        finish_period(SA, 5);
        check("sa_stb_count", stb_cnt - s0, 1);

        // Note change Ni -> Pa
        do_reset();
        s0 = stb_cnt;
        period_n(NI, 5);
        check("ni_valid", note_valid, 1'b1);
        check("ni_idx", note_idx, 3'd6);
        check("ni_led", led, 7'b1000000);
        period_n(PA, 1);
        period_n(PA, 1);
        check("chg_miss1_hold", note_valid, 1'b1);
        rise_probe();
        check("chg_miss2_early", note_valid, 1'b1);
        tick(1);
        check("chg_drop_valid", note_valid, 1'b0);
        check("chg_drop_led", led, 7'd0);
        check("chg_idx_holds", note_idx, 3'd6);
        finish_period(PA, 4);
        period_n(PA, 2);
        check("chg_acq_valid", note_valid, 1'b0);
        rise_probe();
        check("chg_relock_early", note_valid, 1'b0);
        tick(1);
        check("pa_valid", note_valid, 1'b1);
        check("pa_idx", note_idx, 3'd4);
        check("pa_led", led, 7'b0010000);
        finish_period(PA, 4);
        check("chg_stb_count", stb_cnt - s0, 2);

        // Ga window edges (lo 150, hi 154) and an in-between period
        for (int k = 0; k < 5; k++) begin
            do_reset();
            v0 = valid_cyc;
            period_n(ga_p[k], 6);
            check($sformatf("ga_win_%0d", ga_p[k]), 32'(valid_cyc != v0), 32'(ga_lock[k]));
            if (ga_lock[k]) check($sformatf("ga_idx_%0d", ga_p[k]), note_idx, 3'd2);
        end

        // Silence: outputs drop exactly TMO cycles after the last edge's lock point
        do_reset();
        period_n(GA, 5);
        check("sil_locked", note_valid, 1'b1);
        tick(TMO + 3 - GA);
        check("sil_before_valid", note_valid, 1'b1);
        check("sil_before_silent", silent, 1'b0);
        tick(1);
        check("sil_valid", note_valid, 1'b0);
        check("sil_led", led, 7'd0);
        check("sil_silent", silent, 1'b1);
        period_n(GA, 4);
        check("sil_recover_4", note_valid, 1'b0);
        check("sil_recover_acq", silent, 1'b0);
        period_n(GA, 1);
        check("sil_recover_5", note_valid, 1'b1);
        check("sil_recover_idx", note_idx, 3'd2);

        // Glitch tolerance at Ma: single bad periods separated by a good one never drop lock
        do_reset();
        period_n(MA, 5);
        check("ma_valid", note_valid, 1'b1);
        check("ma_idx", note_idx, 3'd3);
        l0 = low_cyc;
        period_n(100, 1);
        period_n(MA, 1);
        check("glitch1_hold", note_valid, 1'b1);
        period_n(MA, 1);
        period_n(100, 1);
        period_n(MA, 2);
        check("glitch2_hold", note_valid, 1'b1);
        check("glitch_idx", note_idx, 3'd3);
        check("glitch_no_drop", low_cyc - l0, 0);

        // Reset mid-lock
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", note_valid, 1'b0);
        check("mid_rst_idx", note_idx, 3'd0);
        check("mid_rst_led", led, 7'd0);
        check("mid_rst_stb", note_stb, 1'b0);
        check("mid_rst_silent", silent, 1'b1);
        rst = 1'b0;
        period_n(MA, 4);
        check("post_rst_4", note_valid, 1'b0);
        period_n(MA, 1);
        check("post_rst_5", note_valid, 1'b1);
        check("post_rst_idx", note_idx, 3'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
